// File: rtl/game_state_ctrl.sv
// game_state_ctrl: maze-game flow FSM driving sprite/map/score resets, ghost enable, fright mode, lives and level
module game_state_ctrl #(
    parameter int N_GHOSTS     = 2,
    parameter int START_LIVES  = 3,
    parameter int RESUME_DELAY = 250000000,
    parameter int FRIGHT_TIME  = 500000000,
    parameter int DOTS_TOTAL   = 300,
    parameter int X_W          = 6,
    parameter int Y_W          = 5
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    start,
    input  logic [X_W-1:0]          pac_x,
    input  logic [Y_W-1:0]          pac_y,
    input  logic [N_GHOSTS*X_W-1:0] ghost_x,
    input  logic [N_GHOSTS*Y_W-1:0] ghost_y,
    input  logic                    dot_eaten,
    input  logic                    power_pill,
    output logic [2:0]              state,
    output logic                    sprite_reset,
    output logic                    map_wr_reset,
    output logic                    score_reset,
    output logic                    ghost_enable,
    output logic                    frightened,
    output logic [N_GHOSTS-1:0]     ghost_eaten,
    output logic [2:0]              lives,
    output logic [3:0]              level
);
    localparam int DCW = $clog2(DOTS_TOTAL + 1);
    localparam int DW  = $clog2(RESUME_DELAY);
    localparam int FW  = $clog2(FRIGHT_TIME);
    localparam logic [DCW-1:0] DOT_LAST    = DCW'(DOTS_TOTAL - 1);
    localparam logic [DW-1:0]  DELAY_LOAD  = DW'(RESUME_DELAY - 1);
    localparam logic [FW-1:0]  FRIGHT_LOAD = FW'(FRIGHT_TIME - 1);
    localparam logic [2:0]     LIVES_INIT  = 3'(START_LIVES);

    typedef enum logic [2:0] {INIT = 3'd0, PLAY = 3'd1, RESUME = 3'd2, CLEAR = 3'd3, OVER = 3'd4} state_t;

    state_t              st, st_n;
    logic                start_q;
    logic [N_GHOSTS-1:0] coll, coll_q, eaten_n;
    logic [DCW-1:0]      dot_cnt, dot_n;
    logic [DW-1:0]       delay_cnt, delay_n;
    logic [FW-1:0]       fright_cnt, fright_n;
    logic                fr_n;
    logic [2:0]          lives_n;
    logic [3:0]          level_n;
    logic                start_edge, fr_eff;

    for (genvar i = 0; i < N_GHOSTS; i++) begin : g_coll
        assign coll[i] = (ghost_x[i*X_W +: X_W] == pac_x) && (ghost_y[i*Y_W +: Y_W] == pac_y);
    end

    assign start_edge   = start && !start_q;
    assign fr_eff       = frightened || power_pill;
    assign state        = st;
    assign sprite_reset = (st == INIT) || (st == RESUME) || (st == CLEAR);
    assign map_wr_reset = (st == INIT) || (st == CLEAR) || (st == OVER);
    assign score_reset  = (st == INIT);
    assign ghost_enable = (st == PLAY);

    // state register; reset returns to INIT from anywhere
    always_ff @(posedge CLOCK_50 or posedge reset)
        if (reset) st <= INIT;
        else       st <= st_n;

    // next state plus next values of lives, level, counters, fright and eat pulses
    always_comb begin
        st_n     = st;
        lives_n  = lives;
        level_n  = level;
        dot_n    = dot_cnt;
        delay_n  = delay_cnt;
        eaten_n  = '0;
        fr_n     = frightened;
        fright_n = fright_cnt;
        case (st)
            INIT: begin
                lives_n = LIVES_INIT;
                level_n = 4'd1;
                dot_n   = '0;
                if (start_edge) st_n = PLAY;
            end
            PLAY: begin
                if (dot_eaten) dot_n = dot_cnt + DCW'(1);
                if (dot_eaten && dot_cnt == DOT_LAST) begin
                    st_n    = CLEAR;
                    delay_n = DELAY_LOAD;
                end else if (|coll && !fr_eff) begin
                    lives_n = lives - 3'd1;
                    st_n    = (lives == 3'd1) ? OVER : RESUME;
                    delay_n = DELAY_LOAD;
                end else if (fr_eff) begin
                    eaten_n = coll & ~coll_q;
                end
            end
            RESUME: begin
                if (delay_cnt == '0) st_n = PLAY;
                else delay_n = delay_cnt - DW'(1);
            end
            CLEAR: begin
                if (delay_cnt == '0) begin
                    st_n    = PLAY;
                    dot_n   = '0;
                    level_n = (level == 4'd15) ? 4'd15 : level + 4'd1;
                end else begin
                    delay_n = delay_cnt - DW'(1);
                end
            end
            OVER: if (start_edge) st_n = INIT;
            default: st_n = INIT;
        endcase
        if (st_n != PLAY) begin
            fr_n     = 1'b0;
            fright_n = '0;
        end else if (st == PLAY && power_pill) begin
            fr_n     = 1'b1;
            fright_n = FRIGHT_LOAD;
        end else if (frightened) begin
            if (fright_cnt == '0) fr_n = 1'b0;
            else fright_n = fright_cnt - FW'(1);
        end
    end

    // datapath registers; collision history only tracks while playing
    always_ff @(posedge CLOCK_50 or posedge reset)
        if (reset) begin
            start_q     <= 1'b0;
            coll_q      <= '0;
            dot_cnt     <= '0;
            delay_cnt   <= '0;
            fright_cnt  <= '0;
            frightened  <= 1'b0;
            ghost_eaten <= '0;
            lives       <= LIVES_INIT;
            level       <= 4'd1;
        end else begin
            start_q     <= start;
            coll_q      <= (st == PLAY) ? coll : '0;
            dot_cnt     <= dot_n;
            delay_cnt   <= delay_n;
            fright_cnt  <= fright_n;
            frightened  <= fr_n;
            ghost_eaten <= eaten_n;
            lives       <= lives_n;
            level       <= level_n;
        end
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: directed scenarios against an event-time model of the game flow
module tb_game_state_ctrl;
    localparam int NG = 3, SL = 2, RD = 4, FT = 6, DT = 3, XW = 6, YW = 5;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, dot_eaten = 1'b0, power_pill = 1'b0;
    logic [XW-1:0]    pac_x = '0;
    logic [YW-1:0]    pac_y = '0;
    logic [NG*XW-1:0] ghost_x = '0;
    logic [NG*YW-1:0] ghost_y = '0;
    logic [2:0]       state, lives;
    logic [3:0]       level;
    logic             sprite_reset, map_wr_reset, score_reset, ghost_enable, frightened;
    logic [NG-1:0]    ghost_eaten;
    int  n_tests = 0, n_fail = 0;
    bit  chk_en = 1'b0;

    game_state_ctrl #(.N_GHOSTS(NG), .START_LIVES(SL), .RESUME_DELAY(RD), .FRIGHT_TIME(FT),
                      .DOTS_TOTAL(DT), .X_W(XW), .Y_W(YW)) dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .pac_x(pac_x), .pac_y(pac_y),
        .ghost_x(ghost_x), .ghost_y(ghost_y), .dot_eaten(dot_eaten), .power_pill(power_pill),
        .state(state), .sprite_reset(sprite_reset), .map_wr_reset(map_wr_reset),
        .score_reset(score_reset), .ghost_enable(ghost_enable), .frightened(frightened),
        .ghost_eaten(ghost_eaten), .lives(lives), .level(level));

    always #5 clk = ~clk;

    // model: phases and fright tracked as absolute end cycles rather than down-counters
    int m_state = 0, m_lives = SL, m_level = 1, m_dots = 0, cyc = 0, fr_end = -1, ph_end = 0;
    bit m_start_prev = 1'b0;
    bit [NG-1:0] m_prev = '0, m_eaten = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0; m_lives = SL; m_level = 1; m_dots = 0; fr_end = -1;
            m_start_prev = 1'b0; m_prev = '0; m_eaten = '0;
        end else begin
            bit [NG-1:0] c;
            bit fr, rise;
            int n, was;
            n = cyc + 1;
            was = m_state;
            for (int i = 0; i < NG; i++)
                c[i] = (ghost_x[i*XW +: XW] == pac_x) && (ghost_y[i*YW +: YW] == pac_y);
            fr = (m_state == 1 && cyc <= fr_end) || power_pill;
            rise = start && !m_start_prev;
            m_eaten = '0;
            case (m_state)
                0: begin
                    m_lives = SL; m_level = 1; m_dots = 0;
                    if (rise) m_state = 1;
                end
                1: begin
                    m_dots += int'(dot_eaten);
                    if (dot_eaten && m_dots == DT) begin
                        m_state = 3; ph_end = n + RD;
                    end else if (c != 0 && !fr) begin
                        m_lives--;
                        m_state = (m_lives == 0) ? 4 : 2;
                        ph_end = n + RD;
                    end else if (fr) begin
                        m_eaten = c & ~m_prev;
                    end
                    if (m_state == 1 && power_pill) fr_end = n + FT - 1;
                end
                2: if (n == ph_end) m_state = 1;
                3: if (n == ph_end) begin
                    m_state = 1; m_dots = 0;
                    m_level = (m_level < 15) ? m_level + 1 : 15;
                end
                default: if (rise) m_state = 0;
            endcase
            if (m_state != 1) fr_end = -1;
            m_prev = (was == 1) ? c : '0;
            m_start_prev = start;
            cyc = n;
        end
    end

    function automatic logic [3:0] ctl(input int s);
        case (s)
            0: return 4'b1110;
            1: return 4'b0001;
            2: return 4'b1000;
            3: return 4'b1100;
            default: return 4'b0100;
        endcase
    endfunction

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) if (chk_en) begin
        logic [18:0] act, want;
        act  = {state, sprite_reset, map_wr_reset, score_reset, ghost_enable, frightened, ghost_eaten, lives, level};
        want = {3'(m_state), ctl(m_state), (m_state == 1 && cyc <= fr_end), m_eaten, 3'(m_lives), 4'(m_level)};
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL cycle %0d: got %h expected %h", cyc, act, want);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic place(input int g);
        for (int i = 0; i < NG; i++) begin
            ghost_x[i*XW +: XW] = (i == g) ? pac_x : XW'(10 + i);
            ghost_y[i*YW +: YW] = (i == g) ? pac_y : YW'(9);
        end
    endtask

    initial begin
        pac_x = 6'd3; pac_y = 5'd4; place(-1);
        #2 reset = 1'b1; chk_en = 1'b1;
        #1;
        check("rst_state", state, 0);
        check("rst_ctl", {sprite_reset, map_wr_reset, score_reset, ghost_enable}, 4'b1110);
        check("rst_lives", lives, 2);
        check("rst_level", level, 1);
        tick(); tick(); reset = 1'b0;
        // start edge, then death with lives to spare
        start = 1'b1; tick();
        check("s1_play", state, 1);
        check("s1_genable", ghost_enable, 1);
        place(2); tick();
        check("s1_resume", state, 2);
        check("s1_lives", lives, 1);
        place(-1); repeat (3) tick();
        check("s1_resume_hold", state, 2);
        tick();
        check("s1_back_play", state, 1);
        // last life lost, restart through INIT
        place(0); tick();
        check("s2_over", state, 4);
        check("s2_lives0", lives, 0);
        check("s2_mapwr", map_wr_reset, 1);
        place(-1); start = 1'b0; tick(); start = 1'b1; tick();
        check("s2_init", state, 0);
        start = 1'b0; tick(); start = 1'b1; tick();
        check("s2_play", state, 1);
        check("s2_lives2", lives, 2);
        // frightened eat with held collision
        power_pill = 1'b1; tick(); power_pill = 1'b0;
        check("s3_fright", frightened, 1);
        place(1); tick();
        check("s3_eaten", ghost_eaten, 3'b010);
        check("s3_lives", lives, 2);
        tick();
        check("s3_single_pulse", ghost_eaten, 0);
        tick(); place(-1); tick(); tick();
        check("s3_fright_last", frightened, 1);
        tick();
        check("s3_fright_off", frightened, 0);
        // pill with coincident collision, then reload near expiry
        power_pill = 1'b1; place(0); tick();
        check("s4_state", state, 1);
        check("s4_eaten", ghost_eaten, 3'b001);
        power_pill = 1'b0; place(-1); repeat (4) tick();
        power_pill = 1'b1; tick(); power_pill = 1'b0;
        repeat (5) tick();
        check("s4_extended", frightened, 1);
        tick();
        check("s4_ext_off", frightened, 0);
        // level clear beats a coincident collision
        dot_eaten = 1'b1; tick(); dot_eaten = 1'b0; tick();
        dot_eaten = 1'b1; tick(); dot_eaten = 1'b0; tick();
        dot_eaten = 1'b1; place(2); tick();
        check("s5_clear", state, 3);
        check("s5_lives", lives, 2);
        place(-1); tick(); dot_eaten = 1'b0; tick(); tick();
        check("s5_clear_hold", state, 3);
        tick();
        check("s5_play", state, 1);
        check("s5_level", level, 2);
        // async reset mid-RESUME
        place(1); tick();
        check("s6_resume", state, 2);
        place(-1); tick();
        #1 reset = 1'b1;
        #1;
        check("s6_init", state, 0);
        check("s6_lives", lives, 2);
        check("s6_fright", frightened, 0);
        check("s6_ctl", {sprite_reset, map_wr_reset, score_reset, ghost_enable}, 4'b1110);
        tick(); tick(); reset = 1'b0;
        tick(); tick();
        check("s6_restart", state, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
